std_seq_mult: RTL and testbench

- Iterative unsigned shift-add multiplier with a go/done handshake.
- Sits directly upstream of a std_reg stage and replaces a std_add in the datapath where a product is required: its out drives the register's in, and its done drives the register's write_en.
- Trades throughput for area: one operand bit is processed per cycle, so the block fits the fabric without DSP tiles.
- Result width equals operand width; the result is the low WIDTH bits of the product.

---
 rtl/std_seq_mult.sv | 82 ++++++++
 tb/tb_std_seq_mult.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/std_seq_mult.sv
// std_seq_mult: iterative unsigned shift-add multiplier, one multiplier bit per cycle, go/done handshake
module std_seq_mult #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic [WIDTH-1:0] out,
    output logic             done
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_mcand, r_mplier, r_acc, r_out;
    logic [CW-1:0]    r_cnt;
    logic             r_done;
    logic [WIDTH-1:0] w_acc_nxt;
    logic             w_last;

    // Partial product for the current multiplier bit; the sum wraps mod 2^WIDTH.
    assign w_acc_nxt = r_mplier[0] ? r_acc + r_mcand : r_acc;
    // The WIDTH-th BUSY edge is the completion edge; no early exit keeps latency fixed.
    assign w_last    = r_cnt == CW'(WIDTH - 1);
    assign out       = r_out;
    assign done      = r_done;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic: go is honoured only in IDLE, DONE always returns to IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = go ? BUSY : IDLE;
            BUSY:    w_next = w_last ? DONE : BUSY;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: capture operands on go, shift-add while busy, publish result and pulse done at completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_out    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (go) begin
                        r_mcand  <= left;
                        r_mplier <= right;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                BUSY: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_out  <= w_acc_nxt;
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_std_seq_mult.sv
// tb_std_seq_mult: directed-vector bench for std_seq_mult at WIDTH=32 and WIDTH=1
module tb_std_seq_mult;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        go = 1'b0;
    logic [31:0] left = '0, right = '0, out;
    logic        done;
    logic        go1 = 1'b0, left1 = 1'b0, right1 = 1'b0, out1, done1;
    int          n_cmp = 0, n_err = 0;

    std_seq_mult #(.WIDTH(32)) u32 (
        .clk(clk), .reset(reset), .go(go), .left(left), .right(right), .out(out), .done(done)
    );
    std_seq_mult #(.WIDTH(1)) u1 (
        .clk(clk), .reset(reset), .go(go1), .left(left1), .right(right1), .out(out1), .done(done1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One WIDTH=32 operation; optionally pulse go and scramble operands while busy.
    task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit disturb);
        logic [31:0] prev;
        int first, cnt;
        first = -1;
        cnt = 0;
        @(negedge clk);
        prev = out;
        go = 1'b1;
        left = a;
        right = b;
        for (int k = 1; k <= 36; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                cnt++;
                if (first < 0) first = k;
            end
            if (k == 32) check({tag, "_hold_before"}, out, prev);
            go = disturb && k == 5;
            if (disturb) begin
                left = 32'd100;
                right = 32'd100;
            end
        end
        check({tag, "_done_cycle"}, 32'(first), 32'd33);
        check({tag, "_done_count"}, 32'(cnt), 32'd1);
        check({tag, "_out"}, out, exp);
    endtask

    task automatic run1(input string tag, input logic a, input logic b, input logic exp);
        int first, cnt;
        first = -1;
        cnt = 0;
        @(negedge clk);
        go1 = 1'b1;
        left1 = a;
        right1 = b;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            go1 = 1'b0;
            if (done1) begin
                cnt++;
                if (first < 0) first = k;
            end
        end
        check({tag, "_done_cycle"}, 32'(first), 32'd2);
        check({tag, "_done_count"}, 32'(cnt), 32'd1);
        check({tag, "_out"}, 32'(out1), 32'(exp));
    endtask

    initial begin
        int cnt, bad;
        repeat (2) @(negedge clk);
        check("rst_out", out, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out1", 32'(out1), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        run32("m3x5", 32'd3, 32'd5, 32'd15, 1'b0);
        repeat (5) @(negedge clk);
        check("m3x5_hold_after", out, 32'd15);
        run32("mffx", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        run32("mtrunc", 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b0);
        run32("m9x4", 32'd9, 32'd4, 32'd36, 1'b1);

        cnt = 0;
        bad = 0;
        @(negedge clk);
        go = 1'b1;
        left = 32'd7;
        right = 32'd6;
        for (int k = 1; k <= 102; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                cnt++;
                if (k != 33 && k != 67 && k != 101) bad++;
            end
        end
        go = 1'b0;
        check("held_done_count", 32'(cnt), 32'd3);
        check("held_done_misplaced", 32'(bad), 32'd0);
        check("held_out", out, 32'd42);
        repeat (3) @(negedge clk);

        cnt = 0;
        go = 1'b1;
        left = 32'd5;
        right = 32'd5;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            go = 1'b0;
            if (done) cnt++;
        end
        #2 reset = 1'b0;
        #1;
        check("abort_out", out, 32'd0);
        check("abort_done", 32'(done), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        reset = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("abort_no_done", 32'(cnt), 32'd0);
        check("abort_out_idle", out, 32'd0);
        run32("m2x8", 32'd2, 32'd8, 32'd16, 1'b0);

        run1("w1_1x1", 1'b1, 1'b1, 1'b1);
        run1("w1_1x0", 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
